// File: rtl/sparrow_pkg.sv
// sparrow_pkg: shared types for the sparrow decode stage.
//   alu_op_e   - ALU operation select consumed by execute
//   OPC_*      - RV32I major opcodes handled by decode
//   F7_*       - funct7 encodings used by OP / shift-immediate forms
//   dec_pkt_t  - decoded packet handed from decode to execute
//   f3_to_op   - base (funct7 == 0) funct3 -> ALU op mapping
package sparrow_pkg;

    localparam int unsigned XLEN_P = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_e             op_sel;
        logic [XLEN_P-1:0]   opr_a;
        logic [XLEN_P-1:0]   opr_b;
        logic [4:0]          rd_addr;
        logic                rd_we;
        logic [XLEN_P-1:0]   pc;
        logic                illegal;
    } dec_pkt_t;

    // funct3 mapping shared by OP and OP-IMM when funct7 selects the base op
    function automatic alu_op_e f3_to_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            3'b000:  op = OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = OP_SRL;
            3'b110:  op = OP_OR;
            3'b111:  op = OP_AND;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/sparrow_instr_dec.sv
// sparrow_instr_dec: purely combinational RV32I integer decoder.
//   instr_i      in   32  instruction word
//   pc_i         in   32  instruction PC (AUIPC operand A)
//   rs1_data_i   in   32  register file data for rs1
//   rs2_data_i   in   32  register file data for rs2
//   pkt_o        out  dec_pkt_t  decoded op/operands/rd/pc/illegal
module sparrow_instr_dec
    import sparrow_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output dec_pkt_t    pkt_o
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [31:0] imm_i_s;
    logic [31:0] imm_u_s;
    logic [31:0] shamt_s;

    assign opcode_s = instr_i[6:0];
    assign rd_s     = instr_i[11:7];
    assign funct3_s = instr_i[14:12];
    assign funct7_s = instr_i[31:25];
    assign imm_i_s  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_u_s  = {instr_i[31:12], 12'h000};
    assign shamt_s  = {27'd0, instr_i[24:20]};

    alu_op_e     op_s;
    logic [31:0] opr_a_s;
    logic [31:0] opr_b_s;
    logic        illegal_s;

    // Opcode/funct decode into raw op and operands, flagging unsupported encodings
    always_comb begin
        op_s      = OP_ADD;
        opr_a_s   = 32'h0000_0000;
        opr_b_s   = 32'h0000_0000;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                opr_a_s = rs1_data_i;
                opr_b_s = rs2_data_i;
                if (funct7_s == F7_ZERO) begin
                    op_s = f3_to_op(funct3_s);
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b000)) begin
                    op_s = OP_SUB;
                end else if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
                    op_s = OP_SRA;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                opr_a_s = rs1_data_i;
                if ((funct3_s == 3'b001) || (funct3_s == 3'b101)) begin
                    // Shift-immediate: upper imm bits are funct7, operand is the 5-bit shamt
                    opr_b_s = shamt_s;
                    if ((funct7_s == F7_ALT) && (funct3_s == 3'b101)) begin
                        op_s = OP_SRA;
                    end else if (funct7_s != F7_ZERO) begin
                        illegal_s = 1'b1;
                    end else begin
                        op_s = f3_to_op(funct3_s);
                    end
                end else begin
                    opr_b_s = imm_i_s;
                    op_s    = f3_to_op(funct3_s);
                end
            end
            OPC_LUI: begin
                opr_b_s = imm_u_s;
            end
            OPC_AUIPC: begin
                opr_a_s = pc_i;
                opr_b_s = imm_u_s;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // Packet assembly: illegal instructions become a harmless ADD 0,0 with no write-back
    always_comb begin
        pkt_o.rd_addr = rd_s;
        pkt_o.pc      = pc_i;
        pkt_o.illegal = illegal_s;
        if (illegal_s) begin
            pkt_o.op_sel = OP_ADD;
            pkt_o.opr_a  = 32'h0000_0000;
            pkt_o.opr_b  = 32'h0000_0000;
            pkt_o.rd_we  = 1'b0;
        end else begin
            pkt_o.op_sel = op_s;
            pkt_o.opr_a  = opr_a_s;
            pkt_o.opr_b  = opr_b_s;
            pkt_o.rd_we  = (rd_s != 5'd0);
        end
    end

endmodule

// File: rtl/sparrow_decode.sv
// sparrow_decode: RV32I decode stage between fetch and execute.
// Reads the register file combinationally in the accept cycle and registers
// the decoded packet (latency 1) behind a valid/ready handshake.
// Optional macro SPARROW_DECODE_SKID_EN: adds a second (skid) entry so that
// in_ready_o comes from a flop and has no path from out_ready_i.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   flush_i                    drop held and incoming packets
//   in_valid_i / in_ready_o    fetch-side handshake
//   instr_i, pc_i              instruction word and PC
//   rs1_addr_o, rs2_addr_o     regfile read addresses (combinational)
//   rs1_data_i, rs2_data_i     regfile read data (same cycle)
//   out_valid_o / out_ready_i  execute-side handshake
//   op_sel_o, opr_a_o, opr_b_o ALU op and operands
//   rd_addr_o, rd_we_o         write-back destination and enable
//   out_pc_o, illegal_o        packet PC and illegal-instruction flag
module sparrow_decode
    import sparrow_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output alu_op_e         op_sel_o,
    output logic [XLEN-1:0] opr_a_o,
    output logic [XLEN-1:0] opr_b_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            illegal_o
);

    localparam dec_pkt_t RESET_PKT = '{
        op_sel:  OP_ADD,
        opr_a:   32'h0000_0000,
        opr_b:   32'h0000_0000,
        rd_addr: 5'd0,
        rd_we:   1'b0,
        pc:      RESET_PC,
        illegal: 1'b0
    };

    dec_pkt_t dec_s;
    dec_pkt_t out_q;
    dec_pkt_t out_d;
    logic     out_valid_q;
    logic     out_valid_d;
    logic     accept_s;

    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    sparrow_instr_dec u_instr_dec (
        .instr_i    (instr_i),
        .pc_i       (pc_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .pkt_o      (dec_s)
    );

    assign accept_s = in_valid_i & in_ready_o;

`ifdef SPARROW_DECODE_SKID_EN
    dec_pkt_t skid_q;
    dec_pkt_t skid_d;
    logic     skid_valid_q;
    logic     skid_valid_d;
    logic     in_ready_q;

    assign in_ready_o = in_ready_q;

    // Two-entry next state: output slot refills from skid first, stalls spill into skid
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready_i) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                out_d       = dec_s;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept_s) begin
            skid_d       = dec_s;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = skid_valid_q;
        end
    end

    // Skid entry and registered ready (ready == skid entry free next cycle)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_q       <= RESET_PKT;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end
`else
    assign in_ready_o = ~out_valid_q | out_ready_i;

    // Single output register: flush beats accept, otherwise load, drain or hold
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_d       = dec_s;
            out_valid_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end
`endif

    // Output packet register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q       <= RESET_PKT;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign op_sel_o    = out_q.op_sel;
    assign opr_a_o     = out_q.opr_a;
    assign opr_b_o     = out_q.opr_b;
    assign rd_addr_o   = out_q.rd_addr;
    assign rd_we_o     = out_q.rd_we;
    assign out_pc_o    = out_q.pc;
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_sparrow_decode.sv
// tb_sparrow_decode: directed bench for sparrow_decode (default build).
// Expected packets are queued when the bench sees an accept and compared
// when execute takes a packet.
module tb_sparrow_decode;
    import sparrow_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1_a;
    logic [4:0]  rs2_a;
    logic [31:0] rs1_d;
    logic [31:0] rs2_d;
    logic        out_valid;
    logic        out_ready;
    alu_op_e     op_sel;
    logic [31:0] opr_a;
    logic [31:0] opr_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] out_pc;
    logic        illegal;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t pend;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sparrow_decode #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .instr_i     (instr),
        .pc_i        (pc),
        .rs1_addr_o  (rs1_a),
        .rs2_addr_o  (rs2_a),
        .rs1_data_i  (rs1_d),
        .rs2_data_i  (rs2_d),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .op_sel_o    (op_sel),
        .opr_a_o     (opr_a),
        .opr_b_o     (opr_b),
        .rd_addr_o   (rd_addr),
        .rd_we_o     (rd_we),
        .out_pc_o    (out_pc),
        .illegal_o   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_op"},    32'(op_sel),    32'(OP_ADD));
        chk({tag, "_a"},     opr_a,          32'd0);
        chk({tag, "_b"},     opr_b,          32'd0);
        chk({tag, "_rd"},    32'(rd_addr),   32'd0);
        chk({tag, "_we"},    32'(rd_we),     32'd0);
        chk({tag, "_ill"},   32'(illegal),   32'd0);
        chk({tag, "_pc"},    out_pc,         32'h0000_0000);
    endtask

    // Scoreboard step at the falling edge: pop on an output handshake, push on an input accept
    task automatic check_out();
        exp_t e;
        if (out_valid && out_ready) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_underflow: observed unexpected packet pc=%h expected none", out_pc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pkt_op",  32'(op_sel),  32'(e.op));
                chk("pkt_a",   opr_a,        e.a);
                chk("pkt_b",   opr_b,        e.b);
                chk("pkt_rd",  32'(rd_addr), 32'(e.rd));
                chk("pkt_we",  32'(rd_we),   32'(e.we));
                chk("pkt_pc",  out_pc,       e.pc);
                chk("pkt_ill", 32'(illegal), 32'(e.ill));
            end
        end
        if (flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(pend);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i_w, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic we, input logic ill);
        instr    = i_w;
        pc       = p;
        rs1_d    = r1;
        rs2_d    = r2;
        in_valid = 1'b1;
        pend.op  = op;
        pend.a   = a;
        pend.b   = b;
        pend.rd  = rd;
        pend.we  = we;
        pend.pc  = p;
        pend.ill = ill;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instr     = 32'h0000_0000;
        pc        = 32'h0000_0000;
        rs1_d     = 32'h0000_0000;
        rs2_d     = 32'h0000_0000;
        pend      = '{OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back decode with execute always ready
        drive(32'h002081B3, 32'h0000_0010, 32'd5, 32'd7, OP_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
        #1;
        chk("rs1_addr", 32'(rs1_a), 32'd1);
        chk("rs2_addr", 32'(rs2_a), 32'd2);
        tick();
        chk("add_valid", 32'(out_valid), 32'd1);
        drive(32'h40435293, 32'h0000_0014, 32'h8000_0000, 32'd0, OP_SRA, 32'h8000_0000, 32'd4, 5'd5, 1'b1, 1'b0);
        tick();
        drive(32'hFFF08013, 32'h0000_0018, 32'h0000_0011, 32'd0, OP_ADD, 32'h0000_0011, 32'hFFFF_FFFF, 5'd0, 1'b0, 1'b0);
        tick();
        drive(32'hABCDE0B7, 32'h0000_001C, 32'hDEAD_BEEF, 32'd0, OP_ADD, 32'd0, 32'hABCD_E000, 5'd1, 1'b1, 1'b0);
        tick();
        drive(32'h00001117, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, OP_ADD, 32'h0000_0100, 32'h0000_1000, 5'd2, 1'b1, 1'b0);
        tick();
        drive(32'h40208233, 32'h0000_0104, 32'd9, 32'd3, OP_SUB, 32'd9, 32'd3, 5'd4, 1'b1, 1'b0);
        tick();
        drive(32'h0020B3B3, 32'h0000_0108, 32'd1, 32'd2, OP_SLTU, 32'd1, 32'd2, 5'd7, 1'b1, 1'b0);
        tick();
        drive(32'h0F00F413, 32'h0000_010C, 32'h1234_5678, 32'd0, OP_AND, 32'h1234_5678, 32'h0000_00F0, 5'd8, 1'b1, 1'b0);
        tick();
        drive(32'hFFFFFFFF, 32'h0000_0110, 32'd1, 32'd2, OP_ADD, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1);
        tick();
        chk("illegal_valid", 32'(out_valid), 32'd1);
        chk("illegal_flag",  32'(illegal),   32'd1);
        drive(32'h80208033, 32'h0000_0114, 32'd1, 32'd2, OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        tick();
        drive(32'h40109093, 32'h0000_0118, 32'd1, 32'd0, OP_ADD, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(sb.size()), 32'd0);

        // Execute stalls for three cycles while fetch keeps offering
        out_ready = 1'b0;
        drive(32'h0020C4B3, 32'h0000_0200, 32'h0000_F0F0, 32'h0000_0FF0, OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd9, 1'b1, 1'b0);
        tick();
        drive(32'h0020E533, 32'h0000_0204, 32'd1, 32'd2, OP_OR, 32'd1, 32'd2, 5'd10, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_ready", 32'(in_ready),  32'd0);
            chk("stall_a",     opr_a,          32'h0000_F0F0);
            chk("stall_op",    32'(op_sel),    32'(OP_XOR));
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("stall_drained", 32'(sb.size()), 32'd0);

        // Flush with a held packet and a new packet on the input
        out_ready = 1'b0;
        drive(32'h0020D5B3, 32'h0000_0300, 32'h0000_0080, 32'd3, OP_SRL, 32'h0000_0080, 32'd3, 5'd11, 1'b1, 1'b0);
        tick();
        drive(32'h0020A633, 32'h0000_0304, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 5'd12, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready),  32'd1);
        tick();
        chk("flush_no_capture", 32'(out_valid), 32'd0);
        chk("flush_sb_empty",   32'(sb.size()),  32'd0);

        // Reset asserted while a packet is stalled on the output
        drive(32'hABCDE0B7, 32'h0000_0400, 32'd0, 32'd0, OP_ADD, 32'd0, 32'hABCD_E000, 5'd1, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("prerst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(32'h002081B3, 32'h0000_0500, 32'd20, 32'd22, OP_ADD, 32'd20, 32'd22, 5'd3, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
